// File: rtl/ram_arbiter_pkg.sv
// Shared memory-subsystem constants and types for the RAM arbiter slice.
package mem_pkg;

  localparam int ADDR_SIZE = 4;
  localparam int CELL_SIZE = 16;
  localparam int N_CLIENTS = 2;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CELL_SIZE-1:0] cell_t;

  // One client request as seen on the request channel.
  typedef struct packed {
    logic  we;
    addr_t addr;
    cell_t wdata;
  } mem_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Client request/response channels plus the Ram-facing bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system
// (clients and the Ram block).
interface ram_arbiter_if
  import mem_pkg::*;
#(
  parameter int addr_size = ADDR_SIZE,
  parameter int cell_size = CELL_SIZE,
  parameter int n_clients = N_CLIENTS
);

  // Client request channel (valid/ready per client).
  logic [n_clients-1:0]                req_valid;
  logic [n_clients-1:0]                req_we;
  logic [n_clients-1:0][addr_size-1:0] req_addr;
  logic [n_clients-1:0][cell_size-1:0] req_wdata;
  logic [n_clients-1:0]                req_ready;

  // Read response channel: one-hot valid, shared data bus.
  logic [n_clients-1:0]                rsp_valid;
  logic [cell_size-1:0]                rsp_data;

  // Ram port.
  logic [addr_size-1:0]                ram_ra;
  logic [addr_size-1:0]                ram_wa;
  logic [cell_size-1:0]                ram_data;
  logic                                ram_we;
  logic [cell_size-1:0]                ram_result;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_result,
    output req_ready, rsp_valid, rsp_data,
    output ram_ra, ram_wa, ram_data, ram_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_result,
    input  req_ready, rsp_valid, rsp_data,
    input  ram_ra, ram_wa, ram_data, ram_we
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among n requesters, priority rotating
// to the client just after the last winner.
module rr_arbiter #(
  parameter int n = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] req_i,
  output logic [n-1:0] grant_o
);

  localparam int cw = (n > 1) ? $clog2(n) : 1;

  logic [cw-1:0] rr_ptr_q;
  logic [cw-1:0] rr_ptr_d;
  logic [cw:0]   idx_wide;
  logic [cw-1:0] idx;
  logic          found;

  // Scan from rr_ptr upward, wrapping; the first pending request wins.
  always_comb begin
    grant_o  = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    for (int k = 0; k < n; k++) begin
      // Sum is at most 2n-2, so one subtraction brings it back in range.
      idx_wide = {1'b0, rr_ptr_q} + (cw+1)'(k);
      if (idx_wide >= (cw+1)'(n)) begin
        idx_wide = idx_wide - (cw+1)'(n);
      end
      idx = idx_wide[cw-1:0];
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        rr_ptr_d     = (idx == cw'(n-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Pointer advances past the winner; it holds on idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port Ram arbiter: grants one client per cycle round-robin, drives
// the Ram port from the winner, and routes the Ram's registered read result
// back to the client that issued the read one cycle earlier.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int addr_size = ADDR_SIZE,
  parameter int cell_size = CELL_SIZE,
  parameter int n_clients = N_CLIENTS
) (
  input logic            clk,
  input logic            reset_n,
  ram_arbiter_if.slave   bus
);

  localparam int cw = (n_clients > 1) ? $clog2(n_clients) : 1;

  logic [n_clients-1:0] grant;
  logic                 any_grant;
  logic [cw-1:0]        win_idx;

  logic [addr_size-1:0] sel_addr;
  logic [cell_size-1:0] sel_wdata;
  logic                 sel_we;

  // In-flight read: set for the cycle after a read grant, tagged with owner.
  logic                 rd_pend_q;
  logic                 rd_pend_d;
  logic [cw-1:0]        rsp_tag_q;
  logic [cw-1:0]        rsp_tag_d;

  rr_arbiter #(
    .n (n_clients)
  ) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (bus.req_valid),
    .grant_o (grant)
  );

  assign any_grant     = |grant;
  assign bus.req_ready = grant;

  // Encode the one-hot grant into a client index for the request mux.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < n_clients; i++) begin
      if (grant[i]) begin
        win_idx = cw'(i);
      end
    end
  end

  // Select the winner's request; park the Ram port at zero when idle.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (any_grant) begin
      sel_addr  = bus.req_addr[win_idx];
      sel_wdata = bus.req_wdata[win_idx];
      sel_we    = bus.req_we[win_idx];
    end
  end

  assign bus.ram_ra   = sel_addr;
  assign bus.ram_wa   = sel_addr;
  assign bus.ram_data = sel_wdata;
  assign bus.ram_we   = sel_we;

  // Next response tag: a granted read opens a response slot next cycle.
  always_comb begin
    rd_pend_d = any_grant & ~sel_we;
    rsp_tag_d = any_grant ? win_idx : rsp_tag_q;
  end

  // Response-tag register; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rsp_tag_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  // Decode the tag into a one-hot response valid per client.
  for (genvar gi = 0; gi < n_clients; gi++) begin : g_rsp
    assign bus.rsp_valid[gi] = rd_pend_q && (rsp_tag_q == cw'(gi));
  end

  // Ram output is already registered, so read data passes straight through.
  assign bus.rsp_data = bus.ram_result;

endmodule
